// File: rtl/nf_trace_buf.sv
// Pipeline trace recorder for the nanoFOX core: a circular buffer of per-cycle
// {cycle, pc, stage instructions} snapshots with PC trigger, post-trigger window and cycle limit.
module nf_trace_buf #(
    parameter int unsigned STAGES    = 4,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned POST_TRIG = 8,
    parameter int unsigned CYC_W     = 32,
    localparam int unsigned AW       = $clog2(DEPTH),
    localparam int unsigned CW       = AW + 1,
    localparam int unsigned DW       = CYC_W + 32 * (STAGES + 1)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                en_i,
    input  logic                arm_i,
    input  logic [31:0]         pc_i,
    input  logic [32*STAGES-1:0] instr_i,
    input  logic                trig_en_i,
    input  logic [31:0]         trig_pc_i,
    input  logic [CYC_W-1:0]    cyc_limit_i,
    input  logic [AW-1:0]       rd_addr_i,
    output logic [DW-1:0]       rd_data_o,
    output logic                rd_valid_o,
    output logic [CW-1:0]       count_o,
    output logic [1:0]          state_o,
    output logic [CYC_W-1:0]    cycle_o,
    output logic                halt_o
);

    localparam int unsigned PW = (POST_TRIG > 0) ? $clog2(POST_TRIG + 1) : 1;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCapture = 2'd1,
        StPost    = 2'd2,
        StDone    = 2'd3
    } state_e;

    state_e             state_q;
    logic [AW-1:0]      wr_ptr_q;
    logic [CW-1:0]      count_q;
    logic [CYC_W-1:0]   cycle_q;
    logic [PW-1:0]      post_cnt_q;
    logic               halt_q;
    logic [DW-1:0]      rd_data_q;
    logic               rd_valid_q;

    logic [DW-1:0]      mem_q [DEPTH];

    logic               capturing;
    logic               wr_en;
    logic               count_full;
    logic [CYC_W-1:0]   cycle_nxt;
    logic               limit_hit;
    logic               trig_hit;
    logic [AW-1:0]      rd_base;
    logic [AW-1:0]      rd_idx;
    logic [DW-1:0]      wr_word;

    always_comb begin
        capturing  = (state_q == StCapture) || (state_q == StPost);
        wr_en      = capturing && en_i && !arm_i;
        count_full = (count_q == CW'(DEPTH));
        cycle_nxt  = cycle_q + CYC_W'(1);
        limit_hit  = (cyc_limit_i != CYC_W'(0)) && (cycle_nxt == cyc_limit_i);
        trig_hit   = trig_en_i && (pc_i == trig_pc_i);
        wr_word    = {cycle_q, pc_i, instr_i};
        // Once full, the oldest entry sits at the write pointer.
        rd_base    = count_full ? wr_ptr_q : AW'(0);
        rd_idx     = rd_base + rd_addr_i;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            cycle_q    <= '0;
            post_cnt_q <= '0;
            halt_q     <= 1'b0;
        end else if (arm_i) begin
            state_q    <= StCapture;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            cycle_q    <= '0;
            post_cnt_q <= '0;
            halt_q     <= 1'b0;
        end else if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
            if (!count_full) begin
                count_q <= count_q + CW'(1);
            end
            cycle_q <= cycle_nxt;
            // Cycle limit wins over a trigger landing in the same cycle.
            if (limit_hit) begin
                halt_q  <= 1'b1;
                state_q <= StDone;
            end else if (state_q == StCapture && trig_hit) begin
                if (POST_TRIG == 0) begin
                    state_q <= StDone;
                end else begin
                    post_cnt_q <= PW'(POST_TRIG);
                    state_q    <= StPost;
                end
            end else if (state_q == StPost) begin
                post_cnt_q <= post_cnt_q - PW'(1);
                if (post_cnt_q == PW'(1)) begin
                    state_q <= StDone;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_word;
        end
    end

    // Read-before-write: a coincident write to the same slot returns the old word.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= mem_q[rd_idx];
            rd_valid_q <= ({1'b0, rd_addr_i} < count_q);
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign count_o    = count_q;
    assign state_o    = state_q;
    assign cycle_o    = cycle_q;
    assign halt_o     = halt_q;

endmodule

// File: tb/tb_nf_trace_buf.sv
// Directed bench for nf_trace_buf: a driver queues expected read words, a monitor
// pops and compares them when read data appears; status outputs are checked inline.
module tb_nf_trace_buf;

    localparam int unsigned STAGES    = 4;
    localparam int unsigned DEPTH     = 16;
    localparam int unsigned POST_TRIG = 8;
    localparam int unsigned CYC_W     = 32;
    localparam int unsigned AW        = $clog2(DEPTH);
    localparam int unsigned CW        = AW + 1;
    localparam int unsigned DW        = CYC_W + 32 * (STAGES + 1);

    logic                 clk;
    logic                 resetn;
    logic                 en_i;
    logic                 arm_i;
    logic [31:0]          pc_i;
    logic [32*STAGES-1:0] instr_i;
    logic                 trig_en_i;
    logic [31:0]          trig_pc_i;
    logic [CYC_W-1:0]     cyc_limit_i;
    logic [AW-1:0]        rd_addr_i;
    logic [DW-1:0]        rd_data_o;
    logic                 rd_valid_o;
    logic [CW-1:0]        count_o;
    logic [1:0]           state_o;
    logic [CYC_W-1:0]     cycle_o;
    logic                 halt_o;

    nf_trace_buf #(
        .STAGES    (STAGES),
        .DEPTH     (DEPTH),
        .POST_TRIG (POST_TRIG),
        .CYC_W     (CYC_W)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .en_i        (en_i),
        .arm_i       (arm_i),
        .pc_i        (pc_i),
        .instr_i     (instr_i),
        .trig_en_i   (trig_en_i),
        .trig_pc_i   (trig_pc_i),
        .cyc_limit_i (cyc_limit_i),
        .rd_addr_i   (rd_addr_i),
        .rd_data_o   (rd_data_o),
        .rd_valid_o  (rd_valid_o),
        .count_o     (count_o),
        .state_o     (state_o),
        .cycle_o     (cycle_o),
        .halt_o      (halt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic rd_req = 1'b0;
    int rd_num = 0;

    logic          exp_valid_q [$];
    logic [DW-1:0] exp_data_q  [$];

    function automatic logic [31:0] mk_instr(input logic [31:0] pc, input int k);
        return pc ^ (32'(k + 1) << 24);
    endfunction

    function automatic logic [DW-1:0] mk_entry(input logic [CYC_W-1:0] cyc,
                                                input logic [31:0] pc);
        logic [DW-1:0] e;
        e = '0;
        for (int k = 0; k < int'(STAGES); k++) e[32*k +: 32] = mk_instr(pc, k);
        e[32*STAGES +: 32]     = pc;
        e[32*(STAGES+1) +: CYC_W] = cyc;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [31:0] pc);
        @(negedge clk);
        en_i = en;
        pc_i = pc;
        for (int k = 0; k < int'(STAGES); k++) instr_i[32*k +: 32] = mk_instr(pc, k);
        @(posedge clk);
        #1 en_i = 1'b0;
    endtask

    task automatic arm();
        @(negedge clk);
        arm_i = 1'b1;
        @(posedge clk);
        #1 arm_i = 1'b0;
    endtask

    task automatic rd(input int addr, input logic valid, input logic [CYC_W-1:0] cyc,
                      input logic [31:0] pc);
        @(negedge clk);
        rd_addr_i = AW'(addr);
        exp_valid_q.push_back(valid);
        exp_data_q.push_back(mk_entry(cyc, pc));
        rd_req = 1'b1;
        @(posedge clk);
        #1 rd_req = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 20;
        while (exp_valid_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        n_cmp++;
        if (exp_valid_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending reads want 0", exp_valid_q.size());
        end
    endtask

    // Monitor: a read requested at a rising edge is valid by the following falling edge.
    initial begin
        logic          ev;
        logic [DW-1:0] ed;
        forever begin
            @(posedge clk);
            if (rd_req) begin
                @(negedge clk);
                rd_num++;
                n_cmp++;
                if (exp_valid_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rd%0d: got unexpected read want queued entry", rd_num);
                end else begin
                    ev = exp_valid_q.pop_front();
                    ed = exp_data_q.pop_front();
                    if (rd_valid_o !== ev) begin
                        n_err++;
                        $display("FAIL rd%0d valid: got %0b want %0b", rd_num, rd_valid_o, ev);
                    end else if (ev && rd_data_o !== ed) begin
                        n_err++;
                        $display("FAIL rd%0d data: got 0x%0h want 0x%0h", rd_num, rd_data_o, ed);
                    end
                end
            end
        end
    end

    initial begin
        resetn      = 1'b0;
        en_i        = 1'b0;
        arm_i       = 1'b0;
        pc_i        = '0;
        instr_i     = '0;
        trig_en_i   = 1'b0;
        trig_pc_i   = '0;
        cyc_limit_i = '0;
        rd_addr_i   = '0;

        #12;
        check("reset state", 64'(state_o), 64'd0);
        check("reset count", 64'(count_o), 64'd0);
        check("reset cycle", 64'(cycle_o), 64'd0);
        check("reset halt", 64'(halt_o), 64'd0);
        check("reset rd_valid", 64'(rd_valid_o), 64'd0);
        check("reset rd_data zero", 64'(rd_data_o == '0), 64'd1);
        @(negedge clk);
        resetn = 1'b1;

        // IDLE ignores enable.
        drive(1'b1, 32'h0);
        check("idle count", 64'(count_o), 64'd0);

        // Basic capture.
        arm();
        check("arm state", 64'(state_o), 64'd1);
        for (int i = 0; i < 5; i++) drive(1'b1, 32'(4 * i));
        check("basic count", 64'(count_o), 64'd5);
        check("basic cycle", 64'(cycle_o), 64'd5);
        rd(0, 1'b1, 0, 32'h0);
        rd(4, 1'b1, 4, 32'h10);
        rd(5, 1'b0, 0, 32'h0);
        drain();

        // Wrap.
        arm();
        for (int i = 0; i < 20; i++) drive(1'b1, 32'(4 * i));
        check("wrap count", 64'(count_o), 64'd16);
        rd(0, 1'b1, 4, 32'h10);
        rd(15, 1'b1, 19, 32'h4C);
        drain();

        // Trigger with post window.
        arm();
        trig_en_i = 1'b1;
        trig_pc_i = 32'h40;
        for (int i = 0; i < 17; i++) drive(1'b1, 32'(4 * i));
        check("trig post state", 64'(state_o), 64'd2);
        for (int i = 17; i < 25; i++) drive(1'b1, 32'(4 * i));
        check("trig done state", 64'(state_o), 64'd3);
        check("trig cycle", 64'(cycle_o), 64'd25);
        drive(1'b1, 32'h40);
        check("done holds cycle", 64'(cycle_o), 64'd25);
        rd(15, 1'b1, 24, 32'h60);
        drain();
        trig_en_i = 1'b0;

        // Cycle limit.
        arm();
        cyc_limit_i = CYC_W'(200);
        for (int i = 0; i < 199; i++) drive(1'b1, 32'(4 * i));
        check("limit halt early", 64'(halt_o), 64'd0);
        drive(1'b1, 32'(4 * 199));
        check("limit halt", 64'(halt_o), 64'd1);
        check("limit state", 64'(state_o), 64'd3);
        check("limit cycle", 64'(cycle_o), 64'd200);
        drive(1'b1, 32'h1000);
        drive(1'b1, 32'h1004);
        check("limit cycle held", 64'(cycle_o), 64'd200);
        rd(15, 1'b1, 199, 32'(4 * 199));
        drain();
        cyc_limit_i = '0;

        // Gated enable.
        arm();
        check("rearm halt clear", 64'(halt_o), 64'd0);
        for (int i = 0; i < 10; i++) drive((i % 2) == 0, 32'(4 * i));
        check("gated cycle", 64'(cycle_o), 64'd5);
        check("gated count", 64'(count_o), 64'd5);
        rd(2, 1'b1, 2, 32'h10);
        rd(4, 1'b1, 4, 32'h20);
        drain();

        // Re-arm from POST.
        arm();
        trig_en_i = 1'b1;
        trig_pc_i = 32'h8;
        for (int i = 0; i < 4; i++) drive(1'b1, 32'(4 * i));
        check("early post state", 64'(state_o), 64'd2);
        arm();
        check("rearm state", 64'(state_o), 64'd1);
        check("rearm count", 64'(count_o), 64'd0);
        check("rearm cycle", 64'(cycle_o), 64'd0);
        trig_en_i = 1'b0;

        // Asynchronous reset mid-capture.
        for (int i = 0; i < 3; i++) drive(1'b1, 32'(4 * i));
        rd(1, 1'b1, 1, 32'h4);
        drain();
        #2 resetn = 1'b0;
        #1;
        check("async state", 64'(state_o), 64'd0);
        check("async count", 64'(count_o), 64'd0);
        check("async cycle", 64'(cycle_o), 64'd0);
        check("async rd_valid", 64'(rd_valid_o), 64'd0);
        check("async rd_data zero", 64'(rd_data_o == '0), 64'd1);
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
